// File: rtl/l_class_oc_indication_arb.sv
// Round-robin arbiter sharing one downstream indication port among NREQ
// requesters, each with a one-entry holding slot and ENA/RDY handshakes.
module l_class_oc_indication_arb #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NREQ-1:0]     req_heard__ENA,
    input  logic [W*NREQ-1:0]   req_meth,
    input  logic [W*NREQ-1:0]   req_v,
    output logic [NREQ-1:0]     req_heard__RDY,
    output logic                out_heard__ENA,
    output logic [W-1:0]        out_meth,
    output logic [W-1:0]        out_v,
    output logic [2:0]          out_src,
    input  logic                out_heard__RDY,
    output logic [31:0]         sent_count
);

    logic [NREQ-1:0] full;
    logic [W-1:0]    meth_q [NREQ];
    logic [W-1:0]    v_q    [NREQ];
    logic [2:0]      ptr;
    logic [2:0]      ptr_next;

    logic            win_valid;
    logic [2:0]      win_idx;
    logic            hi_found;
    logic [2:0]      hi_idx;
    logic [2:0]      lo_idx;
    logic            xfer;
    logic [NREQ-1:0] cap;

    // Rotating priority without modulo: prefer the lowest full slot at or
    // above ptr, otherwise wrap around to the lowest full slot overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (full[i]) begin
                lo_idx = 3'(i);
                if (3'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        win_valid = |full;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        out_meth = '0;
        out_v    = '0;
        out_src  = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_valid && (win_idx == 3'(i))) begin
                out_meth = meth_q[i];
                out_v    = v_q[i];
                out_src  = 3'(i);
            end
        end
    end

    assign out_heard__ENA = win_valid;
    assign req_heard__RDY = ~full;
    assign xfer           = win_valid && out_heard__RDY;
    assign cap            = req_heard__ENA & ~full;
    assign ptr_next       = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            full       <= '0;
            ptr        <= 3'd0;
            sent_count <= 32'd0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer && (win_idx == 3'(i))) begin
                    full[i] <= 1'b0;
                end
                if (cap[i]) begin
                    full[i] <= 1'b1;
                end
            end
            if (xfer) begin
                ptr        <= ptr_next;
                sent_count <= sent_count + 32'd1;
            end
        end
    end

    // Slot payload needs no reset; it is only observed while full is set.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (nRST && cap[i]) begin
                meth_q[i] <= req_meth[W*i +: W];
                v_q[i]    <= req_v[W*i +: W];
            end
        end
    end

endmodule

// File: tb/tb_l_class_oc_indication_arb.sv
// Scoreboard bench for l_class_oc_indication_arb: directed scenarios followed
// by random traffic, checked against a slot/queue reference model.
module tb_l_class_oc_indication_arb;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [NREQ-1:0]     req_heard__ENA;
    logic [W*NREQ-1:0]   req_meth;
    logic [W*NREQ-1:0]   req_v;
    logic [NREQ-1:0]     req_heard__RDY;
    logic                out_heard__ENA;
    logic [W-1:0]        out_meth;
    logic [W-1:0]        out_v;
    logic [2:0]          out_src;
    logic                out_heard__RDY;
    logic [31:0]         sent_count;

    always #5 CLK = ~CLK;

    l_class_oc_indication_arb #(.NREQ(NREQ), .W(W)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .req_heard__ENA (req_heard__ENA),
        .req_meth       (req_meth),
        .req_v          (req_v),
        .req_heard__RDY (req_heard__RDY),
        .out_heard__ENA (out_heard__ENA),
        .out_meth       (out_meth),
        .out_v          (out_v),
        .out_src        (out_src),
        .out_heard__RDY (out_heard__RDY),
        .sent_count     (sent_count)
    );

    typedef struct {
        logic [2:0]   src;
        logic [W-1:0] meth;
        logic [W-1:0] v;
    } xfer_t;

    xfer_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Reference model: slot contents, pointer, transfer count
    bit           m_full [NREQ];
    logic [W-1:0] m_meth [NREQ];
    logic [W-1:0] m_v    [NREQ];
    int           m_ptr;
    logic [31:0]  m_cnt;

    // Values the DUT should be presenting during the current cycle
    logic [NREQ-1:0] e_rdy;
    logic            e_ena;
    logic [31:0]     e_cnt;
    logic [2:0]      e_src;
    logic [W-1:0]    e_meth;
    logic [W-1:0]    e_v;
    bit              model_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner();
        for (int k = 0; k < NREQ; k++) begin
            int s = (m_ptr + k) % NREQ;
            if (m_full[s]) return s;
        end
        return -1;
    endfunction

    // Drive one cycle's inputs and advance the model across the coming edge.
    task automatic step(input logic rst_n, input logic [NREQ-1:0] ena,
                        input logic [W*NREQ-1:0] meth, input logic [W*NREQ-1:0] v,
                        input logic rdy);
        int w;
        bit old_full [NREQ];
        @(negedge CLK);
        nRST           = rst_n;
        req_heard__ENA = ena;
        req_meth       = meth;
        req_v          = v;
        out_heard__RDY = rdy;

        w = m_winner();
        for (int i = 0; i < NREQ; i++) e_rdy[i] = !m_full[i];
        e_ena  = (w >= 0);
        e_cnt  = m_cnt;
        e_src  = (w >= 0) ? 3'(w) : 3'd0;
        e_meth = (w >= 0) ? m_meth[w] : '0;
        e_v    = (w >= 0) ? m_v[w] : '0;
        model_valid = 1'b1;

        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) m_full[i] = 1'b0;
            m_ptr = 0;
            m_cnt = 32'd0;
        end else begin
            old_full = m_full;
            if (w >= 0 && rdy) begin
                exp_q.push_back(xfer_t'{src: 3'(w), meth: m_meth[w], v: m_v[w]});
                m_full[w] = 1'b0;
                m_ptr     = (w + 1) % NREQ;
                m_cnt     = m_cnt + 32'd1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (ena[i] && !old_full[i]) begin
                    m_full[i] = 1'b1;
                    m_meth[i] = meth[W*i +: W];
                    m_v[i]    = v[W*i +: W];
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b1, '0, '0, '0, rdy);
    endtask

    function automatic logic [W*NREQ-1:0] rand_bus();
        logic [W*NREQ-1:0] b;
        for (int i = 0; i < NREQ; i++) b[W*i +: W] = $urandom;
        return b;
    endfunction

    // Monitor: per-cycle output checks and scoreboard pop on each transfer
    always @(negedge CLK) begin
        #1;
        if (model_valid) begin
            chk("req_rdy",    64'(req_heard__RDY), 64'(e_rdy));
            chk("out_ena",    64'(out_heard__ENA), 64'(e_ena));
            chk("sent_count", 64'(sent_count),     64'(e_cnt));
            chk("out_src",    64'(out_src),        64'(e_src));
            chk("out_meth",   64'(out_meth),       64'(e_meth));
            chk("out_v",      64'(out_v),          64'(e_v));
            if (out_heard__ENA && out_heard__RDY && nRST) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL xfer_unexpected: got src %0d expected no transfer at %0t", out_src, $time);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    chk("xfer_src",  64'(out_src),  64'(e.src));
                    chk("xfer_meth", 64'(out_meth), 64'(e.meth));
                    chk("xfer_v",    64'(out_v),    64'(e.v));
                end
            end
        end
    end

    initial begin
        logic [W*NREQ-1:0] mb;
        logic [W*NREQ-1:0] vb;
        nRST = 1'b0; req_heard__ENA = '0; req_meth = '0; req_v = '0; out_heard__RDY = 1'b0;
        for (int i = 0; i < NREQ; i++) begin m_full[i] = 1'b0; m_meth[i] = '0; m_v[i] = '0; end
        m_ptr = 0;
        m_cnt = 32'd0;

        step(1'b0, '0, '0, '0, 1'b1);
        step(1'b0, '1, rand_bus(), rand_bus(), 1'b1);
        idle(1, 1'b1);

        // single call into slot 2
        mb = '0; vb = '0;
        mb[W*2 +: W] = 32'h11; vb[W*2 +: W] = 32'hAB;
        step(1'b1, 4'b0100, mb, vb, 1'b1);
        idle(3, 1'b1);

        // all slots on one edge, meth = index
        for (int i = 0; i < NREQ; i++) mb[W*i +: W] = 32'(i);
        step(1'b1, 4'b1111, mb, rand_bus(), 1'b1);
        idle(6, 1'b1);

        // backpressure on slots 1 and 3
        step(1'b1, 4'b1010, rand_bus(), rand_bus(), 1'b0);
        idle(5, 1'b0);
        idle(4, 1'b1);

        // move ptr to 2 via slot 1, then slots 0 and 3 compete
        step(1'b1, 4'b0010, rand_bus(), rand_bus(), 1'b1);
        idle(1, 1'b1);
        step(1'b1, 4'b1001, rand_bus(), rand_bus(), 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // requester 0 hammering ENA
        for (int c = 0; c < 10; c++) step(1'b1, 4'b0001, rand_bus(), rand_bus(), 1'b1);
        idle(3, 1'b1);

        // reset with three slots pending
        step(1'b1, 4'b0111, rand_bus(), rand_bus(), 1'b0);
        idle(1, 1'b0);
        step(1'b0, 4'b1111, rand_bus(), rand_bus(), 1'b1);
        idle(4, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) != 0), NREQ'($urandom), rand_bus(), rand_bus(),
                 ($urandom_range(0, 9) < 7));
        end
        idle(8, 1'b1);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
